phy_write_sequencer: RTL and testbench
======================================

# phy_write_sequencer

Per-channel WRITE burst sequencer sitting directly upstream of the PHY write-mode data handler inside the PHY controller. On acceptance of a WRITE CAS issue it pulls one burst of beats from the Write Buffer and pushes them into the PHY write FIFO. It then counts out tCWL and asserts the DRAM drive window for exactly one burst. Completion, or abort on buffer underrun, is reported back to the channel controller.

## Interface
Parameters:
- MEM_DATAWIDTH, 64: DQ beat width.
- BURST_LENGTH, 8: beats per burst. Must be a power of two.
- CWL, 12: clk cycles from command accept to the start of the drive window. Elaboration `$error` if CWL < BURST_LENGTH+1.
- DRIVE_CYCLES, 4: clk cycles outflag is held (BURST_LENGTH/2 at clk2x beat rate).
- TPOST, 1: write postamble / turnaround cycles. Must be ≥1.
- ID_W, 4: command tag width.

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  WRITE CAS issued this cycle.
- cmd_id  in  ID_W  tag of the issued WRITE.
- cmd_ready  out  1  sequencer idle; a command can be accepted.
- buf_valid  in  1  Write Buffer head beat valid (first-word fall-through).
- buf_data  in  MEM_DATAWIDTH  head beat data.
- buf_strb  in  MEM_DATAWIDTH/BURST_LENGTH  head beat byte strobes.
- buf_pop  out  1  consume head beat this cycle.
- inflag  out  1  push a beat to the PHY write FIFO.
- inData  out  MEM_DATAWIDTH  beat to the PHY write FIFO.
- inStrb  out  MEM_DATAWIDTH/BURST_LENGTH  strobes to the PHY write FIFO.
- outflag  out  1  DRAM drive window, registered.
- wr_done  out  1  one-cycle completion pulse.
- wr_err  out  1  qualifies wr_done: burst aborted on underrun.
- done_id  out  ID_W  tag of the completing burst, valid with wr_done.

## Operation
- States: IDLE, FILL, WAIT, DRIVE, POST.
- Accept: cmd_valid && cmd_ready at the edge of cycle 0. cmd_id is latched. A cycle counter `cyc` (width $clog2(CWL+DRIVE_CYCLES+TPOST+1)) is set to 1 for cycle 1.
- cmd_ready = (state==IDLE) && !rst. cmd_valid while busy is ignored; no queueing.
- FILL, cycles 1..BURST_LENGTH:
  - inflag = 1; inData/inStrb = buf_data/buf_strb (combinational pass-through).
  - buf_pop = buf_valid.
- Underrun: buf_valid=0 in any FILL cycle.
  - Next state is IDLE; outflag is never asserted for this burst.
  - Next cycle: wr_done=1, wr_err=1, done_id=tag.
- WAIT, cycles BURST_LENGTH+1..CWL-1. Skipped entirely when CWL == BURST_LENGTH+1.
- DRIVE, cycles CWL..CWL+DRIVE_CYCLES-1: outflag=1.
- POST, TPOST cycles: outflag=0.
- Return to IDLE in cycle CWL+DRIVE_CYCLES+TPOST:
  - wr_done=1, wr_err=0, done_id=tag in that cycle.
  - cmd_ready is already 1 in that cycle, so back-to-back accept is legal.
- inflag, buf_pop and wr_done are mutually exclusive with outflag by construction.
- The counter saturates at its terminal value; no wrap occurs within a burst.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE; outflag=0, wr_done=0, wr_err=0, done_id=0.
  - inflag=0, buf_pop=0, cmd_ready=0 while rst=1.
- Reset mid-burst in any state:
  - All outputs drop in the same cycle.
  - No wr_done is generated for the killed burst.
  - cmd_ready rises in the first cycle after rst deasserts.
- Defaults (CWL=12, BL=8, DRIVE=4, TPOST=1):
  - FILL cycles 1–8; WAIT 9–11; DRIVE 12–15; POST 16.
  - wr_done in cycle 17, which is also the next possible accept.
- Maximum throughput: one burst per CWL+DRIVE_CYCLES+TPOST cycles.
- Underrun in FILL cycle k: wr_done/wr_err in cycle k+1. Beats already popped are not replayed.

## Test plan
- Nominal, defaults: accept cmd_id=3 at cycle 0 with buf_valid held high and beats 0xA0..0xA7. Required:
  - inflag and buf_pop high in cycles 1–8; inData carries 0xA0..0xA7 in order.
  - outflag high in cycles 12–15 only.
  - wr_done=1, wr_err=0, done_id=3 in cycle 17.
- Back-to-back: cmd_id=1 accepted at cycle 0, cmd_id=2 presented from cycle 5 onward. Required:
  - The second command is accepted at cycle 17; its FILL is cycles 18–25.
  - done_id=1 at cycle 17 and done_id=2 at cycle 34.
- Underrun: buf_valid=0 in FILL cycle 5. Required:
  - buf_pop=0 in cycle 5; wr_done=1, wr_err=1 in cycle 6.
  - outflag never asserted; cmd_ready=1 in cycle 6.
- Reset in DRIVE: assert rst in cycle 13. Required:
  - outflag=0 immediately; no wr_done for the killed burst.
  - A new cmd accepted right after reset completes normally.
- Boundary CWL=9: required FILL 1–8, no WAIT, DRIVE 9–12, POST 13, wr_done 14.
- Busy drop: cmd_valid pulsed in cycle 10 during WAIT. Required: ignored, and no second wr_done is ever produced.

Source files
------------

// File: rtl/phy_write_sequencer.sv
`default_nettype none
// phy_write_sequencer: pulls one WRITE burst from the Write Buffer into the PHY FIFO, then opens the tCWL-aligned drive window.
// Revision 1.0

module phy_write_sequencer #(
  parameter int MEM_DATAWIDTH = 64,
  parameter int BURST_LENGTH  = 8,
  parameter int CWL           = 12,
  parameter int DRIVE_CYCLES  = 4,
  parameter int TPOST         = 1,
  parameter int ID_W          = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  input  logic [ID_W-1:0]                         cmd_id,
  output logic                                    cmd_ready,
  input  logic                                    buf_valid,
  input  logic [MEM_DATAWIDTH-1:0]                buf_data,
  input  logic [MEM_DATAWIDTH/BURST_LENGTH-1:0]   buf_strb,
  output logic                                    buf_pop,
  output logic                                    inflag,
  output logic [MEM_DATAWIDTH-1:0]                inData,
  output logic [MEM_DATAWIDTH/BURST_LENGTH-1:0]   inStrb,
  output logic                                    outflag,
  output logic                                    wr_done,
  output logic                                    wr_err,
  output logic [ID_W-1:0]                         done_id
);

  localparam int LAST_CYC = CWL + DRIVE_CYCLES + TPOST;
  localparam int CNT_W    = $clog2(LAST_CYC + 1);

  localparam logic [CNT_W-1:0] C_FILL_END  = CNT_W'(BURST_LENGTH);
  localparam logic [CNT_W-1:0] C_WAIT_END  = CNT_W'(CWL - 1);
  localparam logic [CNT_W-1:0] C_DRIVE_END = CNT_W'(CWL + DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_POST_END  = CNT_W'(LAST_CYC - 1);
  localparam logic [CNT_W-1:0] C_TERM      = CNT_W'(LAST_CYC);

  generate
    if (CWL < BURST_LENGTH + 1) begin : g_chk_cwl
      $error("phy_write_sequencer: CWL must be at least BURST_LENGTH+1");
    end
    if ((BURST_LENGTH < 1) || ((BURST_LENGTH & (BURST_LENGTH - 1)) != 0)) begin : g_chk_bl
      $error("phy_write_sequencer: BURST_LENGTH must be a power of two");
    end
    if (TPOST < 1) begin : g_chk_tpost
      $error("phy_write_sequencer: TPOST must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRIVE = 3'd3,
    ST_POST  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] w_cyc_nxt;
  logic [ID_W-1:0]  r_tag;
  logic             r_outflag;
  logic             r_wr_done;
  logic             r_wr_err;
  logic [ID_W-1:0]  r_done_id;
  logic             w_accept;
  logic             w_fin_ok;
  logic             w_fin_err;

  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  // r_cyc holds the cycle number of the burst; cycle 0 is the accept cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = (r_cyc != C_TERM) ? r_cyc + 1'b1 : r_cyc;
    w_fin_ok    = 1'b0;
    w_fin_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cyc_nxt = r_cyc;
        if (w_accept) begin
          w_state_nxt = ST_FILL;
          w_cyc_nxt   = CNT_W'(1);
        end
      end
      ST_FILL: begin
        if (!buf_valid) begin
          w_state_nxt = ST_IDLE;
          w_fin_err   = 1'b1;
        end else if (r_cyc == C_FILL_END) begin
          w_state_nxt = (CWL == BURST_LENGTH + 1) ? ST_DRIVE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cyc == C_WAIT_END) w_state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (r_cyc == C_DRIVE_END) w_state_nxt = ST_POST;
      end
      ST_POST: begin
        if (r_cyc == C_POST_END) begin
          w_state_nxt = ST_IDLE;
          w_fin_ok    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cyc     <= '0;
      r_tag     <= '0;
      r_outflag <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cyc     <= w_cyc_nxt;
      r_outflag <= (w_state_nxt == ST_DRIVE);
      r_wr_done <= w_fin_ok || w_fin_err;
      r_wr_err  <= w_fin_err;
      if (w_accept) r_tag <= cmd_id;
      if (w_fin_ok || w_fin_err) r_done_id <= r_tag;
    end
  end

  assign inflag  = (r_state == ST_FILL);
  assign buf_pop = inflag && buf_valid;
  assign inData  = buf_data;
  assign inStrb  = buf_strb;
  assign outflag = r_outflag;
  assign wr_done = r_wr_done;
  assign wr_err  = r_wr_err;
  assign done_id = r_done_id;

endmodule

`default_nettype wire

// File: tb/tb_phy_write_sequencer.sv
`default_nettype none
// tb_phy_write_sequencer: two DUTs (CWL=12 and CWL=9) on shared stimulus, checked every cycle against a burst-timeline model.
// Revision 1.0

module tb_phy_write_sequencer;

  localparam int BL   = 8;
  localparam int DRV  = 4;
  localparam int TP   = 1;
  localparam int CWL0 = 12;
  localparam int CWL1 = 9;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  id;
    logic        err;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [3:0]  cmd_id;
  logic        buf_valid;
  logic [63:0] buf_data;
  logic [7:0]  buf_strb;

  logic [1:0]  cmd_ready_s, buf_pop_s, inflag_s, outflag_s, wr_done_s, wr_err_s;
  logic [63:0] indata_s  [2];
  logic [7:0]  instrb_s  [2];
  logic [3:0]  done_id_s [2];

  int n_tests;
  int n_fail;
  int cycle;
  int t0;

  // Burst timeline model: cycle number within the current burst, per DUT.
  bit         m_busy  [2];
  int         m_rel   [2];
  logic [3:0] m_tag   [2];
  bit         m_dpend [2];
  bit         m_derr  [2];
  logic [3:0] m_dtag  [2];

  done_t       dq0[$], dq1[$];
  int          oq0[$], oq1[$];
  logic [63:0] iq0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_dut
      phy_write_sequencer #(
        .MEM_DATAWIDTH (64),
        .BURST_LENGTH  (BL),
        .CWL           ((i == 0) ? CWL0 : CWL1),
        .DRIVE_CYCLES  (DRV),
        .TPOST         (TP),
        .ID_W          (4)
      ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id),
        .cmd_ready (cmd_ready_s[i]),
        .buf_valid (buf_valid),
        .buf_data  (buf_data),
        .buf_strb  (buf_strb),
        .buf_pop   (buf_pop_s[i]),
        .inflag    (inflag_s[i]),
        .inData    (indata_s[i]),
        .inStrb    (instrb_s[i]),
        .outflag   (outflag_s[i]),
        .wr_done   (wr_done_s[i]),
        .wr_err    (wr_err_s[i]),
        .done_id   (done_id_s[i])
      );
    end
  endgenerate

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", nm, d, cycle, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : b_cmp
      int   cw;
      logic e_rdy, e_in, e_out;
      cw    = (d == 0) ? CWL0 : CWL1;
      e_rdy = !rst && !m_busy[d];
      e_in  = !rst && m_busy[d] && (m_rel[d] <= BL);
      e_out = !rst && m_busy[d] && (m_rel[d] >= cw) && (m_rel[d] < cw + DRV);
      chk("cmd_ready", d, 64'(cmd_ready_s[d]), 64'(e_rdy));
      chk("inflag",    d, 64'(inflag_s[d]),    64'(e_in));
      chk("buf_pop",   d, 64'(buf_pop_s[d]),   64'(e_in && buf_valid));
      chk("outflag",   d, 64'(outflag_s[d]),   64'(e_out));
      chk("wr_done",   d, 64'(wr_done_s[d]),   64'(!rst && m_dpend[d]));
      if (e_in) begin
        chk("inData", d, indata_s[d], buf_data);
        chk("inStrb", d, 64'(instrb_s[d]), 64'(buf_strb));
      end
      if (rst) begin
        chk("wr_err_rst",  d, 64'(wr_err_s[d]),  64'd0);
        chk("done_id_rst", d, 64'(done_id_s[d]), 64'd0);
      end else if (m_dpend[d]) begin
        chk("wr_err",  d, 64'(wr_err_s[d]),  64'(m_derr[d]));
        chk("done_id", d, 64'(done_id_s[d]), 64'(m_dtag[d]));
      end

      if (rst) begin
        m_busy[d]  <= 1'b0;
        m_dpend[d] <= 1'b0;
      end else begin
        m_dpend[d] <= 1'b0;
        if (m_busy[d]) begin
          if (m_rel[d] <= BL && !buf_valid) begin
            m_busy[d] <= 1'b0; m_dpend[d] <= 1'b1; m_derr[d] <= 1'b1; m_dtag[d] <= m_tag[d];
          end else if (m_rel[d] == cw + DRV + TP - 1) begin
            m_busy[d] <= 1'b0; m_dpend[d] <= 1'b1; m_derr[d] <= 1'b0; m_dtag[d] <= m_tag[d];
          end else begin
            m_rel[d] <= m_rel[d] + 1;
          end
        end else if (cmd_valid) begin
          m_busy[d] <= 1'b1;
          m_rel[d]  <= 1;
          m_tag[d]  <= cmd_id;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_done_s[0]) dq0.push_back('{cyc: cycle, id: done_id_s[0], err: wr_err_s[0]});
      if (wr_done_s[1]) dq1.push_back('{cyc: cycle, id: done_id_s[1], err: wr_err_s[1]});
      if (outflag_s[0]) oq0.push_back(cycle);
      if (outflag_s[1]) oq1.push_back(cycle);
      if (inflag_s[0])  iq0.push_back(indata_s[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int c);
    while (cycle < c) step();
  endtask

  task automatic start_cmd(input logic [3:0] id);
    dq0.delete(); dq1.delete(); oq0.delete(); oq1.delete(); iq0.delete();
    t0        = cycle;
    cmd_valid = 1'b1;
    cmd_id    = id;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0;
    buf_valid = 1'b1; buf_data = '0; buf_strb = 8'hFF;
    repeat (3) step();
    chk("reset_ready", 0, 64'(cmd_ready_s), 64'd0);
    chk("reset_out",   0, 64'(outflag_s | wr_done_s | inflag_s), 64'd0);
    rst = 1'b0;
    step();
    chk("ready_after_reset", 0, 64'(cmd_ready_s), 64'd3);

    // Nominal burst with beats 0xA0..0xA7
    start_cmd(4'd3);
    for (int k = 0; k < BL; k++) begin
      buf_data = 64'hA0 + 64'(k);
      buf_strb = 8'(8'h10 + k);
      step();
    end
    idle_until(t0 + 20);
    chk("nom_out_cnt", 0, 64'(oq0.size()), 64'd4);
    if (oq0.size() > 0) chk("nom_out_first", 0, 64'(oq0[0] - t0), 64'd12);
    chk("nom_done_cnt", 0, 64'(dq0.size()), 64'd1);
    if (dq0.size() > 0) begin
      chk("nom_done_cyc", 0, 64'(int'(dq0[0].cyc) - t0), 64'd17);
      chk("nom_done_id",  0, 64'(dq0[0].id), 64'd3);
      chk("nom_done_err", 0, 64'(dq0[0].err), 64'd0);
    end
    chk("nom_beats", 0, 64'(iq0.size()), 64'd8);
    if (iq0.size() == 8)
      for (int k = 0; k < 8; k++) chk("nom_beat", 0, iq0[k], 64'hA0 + 64'(k));
    chk("cwl9_out_cnt", 1, 64'(oq1.size()), 64'd4);
    if (oq1.size() > 0) chk("cwl9_out_first", 1, 64'(oq1[0] - t0), 64'd9);
    if (dq1.size() > 0) chk("cwl9_done_cyc", 1, 64'(int'(dq1[0].cyc) - t0), 64'd14);
    else chk("cwl9_done_cnt", 1, 64'(dq1.size()), 64'd1);

    // Back-to-back: second command waits from cycle 5
    idle_until(cycle + 3);
    start_cmd(4'd1);
    idle_until(t0 + 5);
    cmd_valid = 1'b1; cmd_id = 4'd2;
    idle_until(t0 + 18);
    cmd_valid = 1'b0;
    idle_until(t0 + 40);
    chk("b2b_done_cnt", 0, 64'(dq0.size()), 64'd2);
    if (dq0.size() == 2) begin
      chk("b2b_done0_cyc", 0, 64'(int'(dq0[0].cyc) - t0), 64'd17);
      chk("b2b_done0_id",  0, 64'(dq0[0].id), 64'd1);
      chk("b2b_done1_cyc", 0, 64'(int'(dq0[1].cyc) - t0), 64'd34);
      chk("b2b_done1_id",  0, 64'(dq0[1].id), 64'd2);
    end
    chk("b2b_cwl9_cnt", 1, 64'(dq1.size()), 64'd2);
    if (dq1.size() == 2) chk("b2b_cwl9_cyc", 1, 64'(int'(dq1[1].cyc) - t0), 64'd28);

    // Underrun in FILL cycle 5
    start_cmd(4'd5);
    for (int k = 1; k <= BL; k++) begin
      buf_valid = (k != 5);
      step();
    end
    buf_valid = 1'b1;
    idle_until(t0 + 25);
    chk("unr_done_cnt", 0, 64'(dq0.size()), 64'd1);
    if (dq0.size() > 0) begin
      chk("unr_done_cyc", 0, 64'(int'(dq0[0].cyc) - t0), 64'd6);
      chk("unr_done_err", 0, 64'(dq0[0].err), 64'd1);
      chk("unr_done_id",  0, 64'(dq0[0].id), 64'd5);
    end
    chk("unr_no_out", 0, 64'(oq0.size() + oq1.size()), 64'd0);

    // Reset during DRIVE
    start_cmd(4'd7);
    idle_until(t0 + 13);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_until(t0 + 25);
    chk("rst_no_done", 0, 64'(dq0.size() + dq1.size()), 64'd0);
    chk("rst_out_cnt", 0, 64'(oq0.size()), 64'd1);
    start_cmd(4'd9);
    idle_until(t0 + 20);
    chk("rst_after_cnt", 0, 64'(dq0.size()), 64'd1);
    if (dq0.size() > 0) begin
      chk("rst_after_cyc", 0, 64'(int'(dq0[0].cyc) - t0), 64'd17);
      chk("rst_after_id",  0, 64'(dq0[0].id), 64'd9);
    end

    // cmd_valid pulsed while busy
    start_cmd(4'd4);
    idle_until(t0 + 10);
    cmd_valid = 1'b1; cmd_id = 4'd11;
    step();
    cmd_valid = 1'b0;
    idle_until(t0 + 40);
    chk("busy_done_cnt",  0, 64'(dq0.size()), 64'd1);
    chk("busy_done_cnt",  1, 64'(dq1.size()), 64'd1);
    if (dq0.size() > 0) chk("busy_done_id", 0, 64'(dq0[0].id), 64'd4);

    // Randomized traffic with sporadic underruns and resets
    for (int n = 0; n < 2500; n++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_id    = 4'($urandom);
      buf_valid = ($urandom_range(0, 15) != 0);
      buf_data  = {$urandom, $urandom};
      buf_strb  = 8'($urandom);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; cmd_valid = 1'b0; buf_valid = 1'b1;
    idle_until(cycle + 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
